// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
// Holds FSM state encodings and the legal operand width range.
package serial_arith_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/fa_cell.sv
// 1-bit full adder cell shared by the bit-serial controllers.
// Ports: A, B, C (carry in) -> S (sum bit), c_out (carry out).
module fa_cell (
    input  logic A,
    input  logic B,
    input  logic C,
    output logic S,
    output logic c_out
);

    assign S     = A ^ B ^ C;
    assign c_out = (A & B) | (B & C) | (A & C);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one fa_cell stepped LSB first over WIDTH clocks.
// Ports: clk, rst (async high), start/a/b/cin in; busy, done, sum, cout out.
module serial_adder_ctrl
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_adder_ctrl: WIDTH out of range");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             fa_s;
    logic             fa_c;

    fa_cell u_fa (
        .A     (a_sr_q[0]),
        .B     (b_sr_q[0]),
        .C     (carry_q),
        .S     (fa_s),
        .c_out (fa_c)
    );

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                // sum_sr and cout are left alone on capture so the
                // previous result stays visible until the first bit edge.
                if (start) begin
                    state_d = ST_RUN;
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
                carry_d  = fa_c;
                cout_d   = fa_c;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_sr_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8).
// Scoreboard queue of a+b+cin results, popped on each done pulse.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic         cout;
    logic [W-1:0] sum;

    logic [W:0]   sb[$];
    logic [W:0]   last_res;
    int           checks = 0;
    int           failures = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Caller is at a negedge; start is held for exactly one edge.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ic);
        start = 1'b1;
        a = ia;
        b = ib;
        cin = ic;
        sb.push_back({1'b0, ia} + {1'b0, ib} + (W+1)'(ic));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered in cycle 1 after capture; returns in the done cycle or on timeout.
    task automatic wait_done(output int cyc, output int bcnt);
        cyc = 1;
        bcnt = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    function automatic logic [W:0] sb_pop();
        if (sb.size() == 0) return 'x;
        return sb.pop_front();
    endfunction

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00", {busy, done});
        end
        checks++;
        if ({cout, sum} !== '0) begin
            failures++;
            $display("FAIL reset_result got=%h exp=000", {cout, sum});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL idle_hold got=%b exp=00", {busy, done});
        end
    endtask

    task automatic test_basic();
        int cyc, bcnt;
        logic [W:0] e;
        issue(8'h5A, 8'h3C, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy_c1 got=%b exp=1", busy);
        end
        wait_done(cyc, bcnt);
        checks++;
        if (cyc != W + 1) begin
            failures++;
            $display("FAIL basic_latency got=%0d exp=%0d", cyc, W + 1);
        end
        checks++;
        if (bcnt != W) begin
            failures++;
            $display("FAIL basic_busy_cycles got=%0d exp=%0d", bcnt, W);
        end
        e = sb_pop();
        checks++;
        if ({cout, sum} !== e) begin
            failures++;
            $display("FAIL basic_result got=%h exp=%h", {cout, sum}, e);
        end
        @(negedge clk);
        checks++;
        if ({done, cout, sum} !== {1'b0, e}) begin
            failures++;
            $display("FAIL basic_after_done got=%h exp=%h", {done, cout, sum}, {1'b0, e});
        end
        last_res = e;
    endtask

    task automatic test_carry();
        int cyc, bcnt;
        logic [W:0] e;
        issue(8'hFF, 8'h01, 1'b0);
        wait_done(cyc, bcnt);
        e = sb_pop();
        checks++;
        if ({cout, sum} !== e) begin
            failures++;
            $display("FAIL carry_ff_01 got=%h exp=%h", {cout, sum}, e);
        end
        @(negedge clk);
        issue(8'hFF, 8'hFF, 1'b1);
        wait_done(cyc, bcnt);
        e = sb_pop();
        checks++;
        if ({cout, sum} !== e) begin
            failures++;
            $display("FAIL carry_ff_ff_1 got=%h exp=%h", {cout, sum}, e);
        end
        checks++;
        if (cyc != W + 1) begin
            failures++;
            $display("FAIL carry_latency got=%0d exp=%0d", cyc, W + 1);
        end
        @(negedge clk);
        last_res = e;
    endtask

    task automatic test_ignore_start();
        int cyc, ndone, first;
        logic [W:0] got, e;
        ndone = 0;
        first = -1;
        got = '0;
        issue(8'h21, 8'h43, 1'b1);
        repeat (2) @(negedge clk);
        start = 1'b1;
        a = 8'h11;
        b = 8'h22;
        @(negedge clk);
        start = 1'b0;
        cyc = 4;
        while (cyc < 20) begin
            if (done === 1'b1) begin
                ndone++;
                if (first < 0) begin
                    first = cyc;
                    got = {cout, sum};
                end
            end
            @(negedge clk);
            cyc++;
        end
        e = sb_pop();
        checks++;
        if (ndone != 1) begin
            failures++;
            $display("FAIL ignore_done_count got=%0d exp=1", ndone);
        end
        checks++;
        if (first != W + 1) begin
            failures++;
            $display("FAIL ignore_latency got=%0d exp=%0d", first, W + 1);
        end
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL ignore_result got=%h exp=%h", got, e);
        end
        last_res = e;
    endtask

    task automatic test_rst_abort();
        int cyc, bcnt, ndone;
        logic [W:0] e;
        ndone = 0;
        issue(8'hC3, 8'h5F, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, cout, sum} !== '0) begin
            failures++;
            $display("FAIL abort_clear got=%h exp=000", {busy, done, cout, sum});
        end
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            failures++;
            $display("FAIL abort_no_done got=%0d exp=0", ndone);
        end
        issue(8'h33, 8'h44, 1'b1);
        wait_done(cyc, bcnt);
        e = sb_pop();
        checks++;
        if (cyc != W + 1 || {cout, sum} !== e) begin
            failures++;
            $display("FAIL abort_recover got=%0d/%h exp=%0d/%h", cyc, {cout, sum}, W + 1, e);
        end
        @(negedge clk);
        last_res = e;
    endtask

    task automatic test_back_to_back();
        int cyc, bcnt;
        logic [W:0] e1, e2;
        start = 1'b1;
        a = 8'h0F;
        b = 8'hF1;
        cin = 1'b0;
        sb.push_back(9'h00F + 9'h0F1);
        @(negedge clk);
        a = 8'hA5;
        b = 8'h5A;
        cin = 1'b1;
        sb.push_back(9'h0A5 + 9'h05A + 9'h001);
        wait_done(cyc, bcnt);
        e1 = sb_pop();
        checks++;
        if (cyc != W + 1 || {cout, sum} !== e1) begin
            failures++;
            $display("FAIL b2b_first got=%0d/%h exp=%0d/%h", cyc, {cout, sum}, W + 1, e1);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({busy, done, cout, sum} !== {2'b10, e1}) begin
            failures++;
            $display("FAIL b2b_rerun got=%h exp=%h", {busy, done, cout, sum}, {2'b10, e1});
        end
        wait_done(cyc, bcnt);
        e2 = sb_pop();
        checks++;
        if (cyc != W + 1) begin
            failures++;
            $display("FAIL b2b_spacing got=%0d exp=%0d", cyc, W + 1);
        end
        checks++;
        if ({cout, sum} !== e2) begin
            failures++;
            $display("FAIL b2b_second got=%h exp=%h", {cout, sum}, e2);
        end
        last_res = e2;
    endtask

    task automatic test_random();
        int cyc, bcnt, gap;
        bit b2b;
        logic [W:0] e;
        b2b = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (!b2b) begin
                gap = $urandom_range(1, 3);
                repeat (gap) begin
                    @(negedge clk);
                    checks++;
                    if ({done, busy, cout, sum} !== {2'b00, last_res}) begin
                        failures++;
                        $display("FAIL rand_idle_hold i=%0d got=%h exp=%h", i, {done, busy, cout, sum}, {2'b00, last_res});
                    end
                end
            end
            issue(W'($urandom()), W'($urandom()), 1'($urandom()));
            checks++;
            if ({done, busy, cout, sum} !== {2'b01, last_res}) begin
                failures++;
                $display("FAIL rand_cycle1 i=%0d got=%h exp=%h", i, {done, busy, cout, sum}, {2'b01, last_res});
            end
            wait_done(cyc, bcnt);
            e = sb_pop();
            checks++;
            if (cyc != W + 1 || bcnt != W) begin
                failures++;
                $display("FAIL rand_timing i=%0d got=%0d/%0d exp=%0d/%0d", i, cyc, bcnt, W + 1, W);
            end
            checks++;
            if ({cout, sum} !== e) begin
                failures++;
                $display("FAIL rand_result i=%0d got=%h exp=%h", i, {cout, sum}, e);
            end
            last_res = e;
            b2b = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
    endtask

    initial begin
        last_res = '0;
        test_reset();
        test_basic();
        test_carry();
        test_ignore_start();
        test_rst_abort();
        test_back_to_back();
        test_random();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
